// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit between the core PC and instruction memory
//
// Takes a fetch request from the core, issues one word read to instruction
// memory, waits a bounded number of cycles for the response and holds the
// result for the core until it is accepted. A redirect (flush) drops any
// in-flight or held fetch, a misaligned PC faults without touching memory,
// and a missing response faults after TIMEOUT cycles.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   pc, fetch_en      fetch address and request from the core
//   flush             redirect: drop in-flight or held fetch
//   inst_valid        inst / inst_pc / fault / fault_cause valid to the core
//   inst, inst_pc     fetched word (0 on fault) and the address it came from
//   inst_ready        core accepts the held instruction
//   fault             fetch faulted (qualified by inst_valid)
//   fault_cause       01 misaligned, 10 bus error, 11 timeout, 00 none
//   mem_req_valid     read request valid
//   mem_req_addr      word-aligned read address
//   mem_req_ready     memory accepts the request
//   mem_rsp_valid     read data valid (always accepted)
//   mem_rsp_data      read data
//   mem_rsp_err       bus error, qualified by mem_rsp_valid
//   busy              unit is not idle

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    input  logic        flush,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUS_ERR  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] addr_q;
    logic [31:0] inst_q;
    logic        fault_q;
    logic [1:0]  cause_q;
    logic [7:0]  cnt_q;
    logic        discard_q;

    logic        misaligned;
    logic        take_pc;
    logic        timeout_hit;
    logic        wait_done;
    logic        drop;

    assign misaligned = (pc[1:0] != 2'b00);

    // A new PC is captured from IDLE, or from HOLD when the core accepts the
    // held instruction and asks for the next one in the same cycle. A flush
    // in that cycle suppresses the capture; the core re-requests afterwards.
    assign take_pc = fetch_en && !flush &&
                     ((state_q == ST_IDLE) ||
                      ((state_q == ST_HOLD) && inst_ready));

    assign timeout_hit = (cnt_q == TIMEOUT);

    // WAIT ends on a response or on timeout; a response wins if both coincide.
    assign wait_done = (state_q == ST_WAIT) && (mem_rsp_valid || timeout_hit);

    // A flush arriving in the same cycle as the response drops it as well.
    assign drop = discard_q || flush;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take_pc) begin
                    state_d = misaligned ? ST_HOLD : ST_REQ;
                end
            end
            ST_REQ: begin
                // The request is never withdrawn once raised, even on flush;
                // the discard flag takes care of the answer.
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_done) begin
                    state_d = drop ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (inst_ready) begin
                    if (take_pc) begin
                        state_d = misaligned ? ST_HOLD : ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: everything is driven from registers only
    // ------------------------------------------------------------------
    always_comb begin
        inst_valid    = 1'b0;
        inst          = 32'd0;
        fault         = 1'b0;
        fault_cause   = CAUSE_NONE;
        mem_req_valid = 1'b0;
        inst_pc       = addr_q;
        mem_req_addr  = {addr_q[31:2], 2'b00};
        busy          = (state_q != ST_IDLE);
        case (state_q)
            ST_REQ: begin
                mem_req_valid = 1'b1;
            end
            ST_HOLD: begin
                inst_valid  = 1'b1;
                inst        = inst_q;
                fault       = fault_q;
                fault_cause = cause_q;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: fetch address, held result, wait counter, discard flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= RESET_PC;
            inst_q    <= 32'd0;
            fault_q   <= 1'b0;
            cause_q   <= CAUSE_NONE;
            cnt_q     <= 8'd0;
            discard_q <= 1'b0;
        end else begin
            if (take_pc) begin
                addr_q <= pc;
                if (misaligned) begin
                    inst_q  <= 32'd0;
                    fault_q <= 1'b1;
                    cause_q <= CAUSE_MISALIGN;
                end
            end

            if ((state_q == ST_REQ) && mem_req_ready) begin
                cnt_q <= 8'd0;
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (wait_done && !drop) begin
                if (mem_rsp_valid) begin
                    inst_q  <= mem_rsp_err ? 32'd0 : mem_rsp_data;
                    fault_q <= mem_rsp_err;
                    cause_q <= mem_rsp_err ? CAUSE_BUS_ERR : CAUSE_NONE;
                end else begin
                    inst_q  <= 32'd0;
                    fault_q <= 1'b1;
                    cause_q <= CAUSE_TIMEOUT;
                end
            end

            // Discard lives from the flush until the outstanding read resolves.
            if (wait_done) begin
                discard_q <= 1'b0;
            end else if (flush && ((state_q == ST_REQ) || (state_q == ST_WAIT))) begin
                discard_q <= 1'b1;
            end
        end
    end

endmodule
